// File: rtl/can_rx_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : can_rx_frame_ctrl_if                                         |
// | Description : Bit-sample bus between a CAN bit sampler/destuffer and the   |
// |               receive frame controller.                                    |
// |               master : drives the per-bit strobe, bit value and destuffer  |
// |                        flags, and observes the frame results.              |
// |               slave  : the frame controller.                               |
// |   i_Sample        one-cycle bit sample strobe                              |
// |   i_Rx_Bit        sampled bus bit (0 = dominant)                           |
// |   i_Ignora_Bit    current sample is a stuff bit                            |
// |   i_Eror_Stuffing 6th equal bit seen by the destuffer                      |
// |   o_Destuff_En    stuffed region active (SOF .. last CRC bit)              |
// |   o_Id/o_Rtr/o_Dlc/o_Data  captured frame fields                           |
// |   o_Frame_Valid/o_Form_Error/o_Stuff_Error/o_Crc_Error  one-cycle pulses   |
// |   o_Busy          controller not idle                                      |
// | MAX_BYTES must match the controller's MAX_BYTES (sets o_Data width).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface can_rx_frame_ctrl_if #(
  parameter int MAX_BYTES = 8
);
  logic                   i_Sample;
  logic                   i_Rx_Bit;
  logic                   i_Ignora_Bit;
  logic                   i_Eror_Stuffing;
  logic                   o_Destuff_En;
  logic [10:0]            o_Id;
  logic                   o_Rtr;
  logic [3:0]             o_Dlc;
  logic [8*MAX_BYTES-1:0] o_Data;
  logic                   o_Frame_Valid;
  logic                   o_Form_Error;
  logic                   o_Stuff_Error;
  logic                   o_Crc_Error;
  logic                   o_Busy;

  modport master (
    output i_Sample, i_Rx_Bit, i_Ignora_Bit, i_Eror_Stuffing,
    input  o_Destuff_En, o_Id, o_Rtr, o_Dlc, o_Data,
    input  o_Frame_Valid, o_Form_Error, o_Stuff_Error, o_Crc_Error, o_Busy
  );

  modport slave (
    input  i_Sample, i_Rx_Bit, i_Ignora_Bit, i_Eror_Stuffing,
    output o_Destuff_En, o_Id, o_Rtr, o_Dlc, o_Data,
    output o_Frame_Valid, o_Form_Error, o_Stuff_Error, o_Crc_Error, o_Busy
  );
endinterface
`default_nettype wire

// File: rtl/can_rx_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : can_rx_frame_ctrl                                            |
// | Description : CAN 2.0A (standard ID) receive frame controller. Consumes    |
// |               destuffed bit samples, captures ID/RTR/DLC/data, checks the  |
// |               fixed-form fields and reports frame completion or errors.    |
// | Ports       : i_Clk    system clock, rising edge                           |
// |               i_Rst_n  asynchronous active-low reset                       |
// |               bus      can_rx_frame_ctrl_if.slave (sample strobe, bit,     |
// |                        destuffer flags in; captured fields, pulses out)    |
// | Parameters  : EOF_BITS  recessive bits in EOF and to leave WAIT_IDLE       |
// |               MAX_BYTES max captured data bytes (DLC clamped), <= 15       |
// | Build option: CAN_RX_CRC_CHECK_EN - when defined, CRC-15 is computed and   |
// |               checked; otherwise no CRC logic and o_Crc_Error is 0.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module can_rx_frame_ctrl #(
  parameter int EOF_BITS  = 7,
  parameter int MAX_BYTES = 8
) (
  input  wire logic           i_Clk,
  input  wire logic           i_Rst_n,
  can_rx_frame_ctrl_if.slave  bus
);

  localparam int         DW       = 8 * MAX_BYTES;
  localparam logic [6:0] EOF_LAST = 7'(EOF_BITS - 1);
  localparam logic [3:0] MAX_LEN  = 4'(MAX_BYTES);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ID        = 4'd1;
  localparam logic [3:0] S_CTRL      = 4'd2;
  localparam logic [3:0] S_DLC       = 4'd3;
  localparam logic [3:0] S_DATA      = 4'd4;
  localparam logic [3:0] S_CRC       = 4'd5;
  localparam logic [3:0] S_CRC_DEL   = 4'd6;
  localparam logic [3:0] S_ACK       = 4'd7;
  localparam logic [3:0] S_ACK_DEL   = 4'd8;
  localparam logic [3:0] S_EOF       = 4'd9;
  localparam logic [3:0] S_WAIT_IDLE = 4'd10;

  logic [3:0]    state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          destuff_q, destuff_d;
  logic [10:0]   id_q, id_d;
  logic          rtr_q, rtr_d;
  logic [3:0]    dlc_q, dlc_d;
  logic [DW-1:0] data_q, data_d;
  logic [6:0]    data_bits_q, data_bits_d;
  logic          frame_valid_q, frame_valid_d;
  logic          form_err_q, form_err_d;
  logic          stuff_err_q, stuff_err_d;

  logic          w_bit;
  logic          w_consume;
  logic          w_stuff_err;
  logic          w_crc_bad;
  logic [3:0]    w_dlc_new;
  logic [3:0]    w_len;
  logic [DW-1:0] w_data_bit;

  assign w_bit = bus.i_Rx_Bit;

  // Stuff bits are only discarded inside the stuffed region; outside it every
  // strobed sample is a real bit.
  assign w_consume   = bus.i_Sample & (~bus.i_Ignora_Bit | ~destuff_q);
  assign w_stuff_err = bus.i_Sample & bus.i_Eror_Stuffing & destuff_q;

  // DLC including the bit being consumed, and the clamped byte count.
  assign w_dlc_new = {dlc_q[2:0], w_bit};
  always_comb begin
    w_len = w_dlc_new;
    if (rtr_q) begin
      w_len = 4'd0;
    end else if (w_dlc_new > MAX_LEN) begin
      w_len = MAX_LEN;
    end
  end

  // Data is filled MSB first from the top of the register; bytes past the
  // received length stay at the zero loaded at SOF.
  assign w_data_bit = {w_bit, {(DW-1){1'b0}}} >> cnt_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    destuff_d     = destuff_q;
    id_d          = id_q;
    rtr_d         = rtr_q;
    dlc_d         = dlc_q;
    data_d        = data_q;
    data_bits_d   = data_bits_q;
    frame_valid_d = 1'b0;
    form_err_d    = 1'b0;
    stuff_err_d   = 1'b0;

    if (w_stuff_err) begin
      state_d     = S_WAIT_IDLE;
      cnt_d       = 7'd0;
      destuff_d   = 1'b0;
      stuff_err_d = 1'b1;
    end else if (w_consume) begin
      cnt_d = cnt_q + 7'd1;
      case (state_q)
        S_IDLE: begin
          if (!w_bit) begin
            state_d     = S_ID;
            destuff_d   = 1'b1;
            id_d        = 11'd0;
            rtr_d       = 1'b0;
            dlc_d       = 4'd0;
            data_d      = '0;
            data_bits_d = 7'd0;
          end
        end
        S_ID: begin
          id_d = {id_q[9:0], w_bit};
          if (cnt_q == 7'd10) state_d = S_CTRL;
        end
        S_CTRL: begin
          if (cnt_q == 7'd0) begin
            rtr_d = w_bit;
          end else if (cnt_q == 7'd1) begin
            // Extended frames are not supported: IDE must be dominant.
            if (w_bit) begin
              form_err_d = 1'b1;
              state_d    = S_WAIT_IDLE;
              destuff_d  = 1'b0;
            end
          end else begin
            state_d = S_DLC;
          end
        end
        S_DLC: begin
          dlc_d = w_dlc_new;
          if (cnt_q == 7'd3) begin
            data_bits_d = {w_len, 3'b000};
            state_d     = (w_len == 4'd0) ? S_CRC : S_DATA;
          end
        end
        S_DATA: begin
          data_d = data_q | w_data_bit;
          if (cnt_q == data_bits_q - 7'd1) state_d = S_CRC;
        end
        S_CRC: begin
          if (cnt_q == 7'd14) begin
            state_d   = S_CRC_DEL;
            destuff_d = 1'b0;
          end
        end
        S_CRC_DEL: begin
          if (!w_bit) begin
            form_err_d = 1'b1;
            state_d    = S_WAIT_IDLE;
          end else begin
            state_d = S_ACK;
          end
        end
        S_ACK: begin
          state_d = S_ACK_DEL;
        end
        S_ACK_DEL: begin
          if (!w_bit) begin
            form_err_d = 1'b1;
            state_d    = S_WAIT_IDLE;
          end else begin
            state_d = S_EOF;
          end
        end
        S_EOF: begin
          if (!w_bit) begin
            form_err_d = 1'b1;
            state_d    = S_WAIT_IDLE;
          end else if (cnt_q == EOF_LAST) begin
            state_d       = S_IDLE;
            frame_valid_d = ~w_crc_bad;
          end
        end
        S_WAIT_IDLE: begin
          if (!w_bit) begin
            cnt_d = 7'd0;
          end else if (cnt_q == EOF_LAST) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d   = S_IDLE;
          destuff_d = 1'b0;
        end
      endcase
      if (state_d != state_q) cnt_d = 7'd0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 7'd0;
      destuff_q     <= 1'b0;
      id_q          <= 11'd0;
      rtr_q         <= 1'b0;
      dlc_q         <= 4'd0;
      data_q        <= '0;
      data_bits_q   <= 7'd0;
      frame_valid_q <= 1'b0;
      form_err_q    <= 1'b0;
      stuff_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      destuff_q     <= destuff_d;
      id_q          <= id_d;
      rtr_q         <= rtr_d;
      dlc_q         <= dlc_d;
      data_q        <= data_d;
      data_bits_q   <= data_bits_d;
      frame_valid_q <= frame_valid_d;
      form_err_q    <= form_err_d;
      stuff_err_q   <= stuff_err_d;
    end
  end

`ifdef CAN_RX_CRC_CHECK_EN
  logic [14:0] crc_q, crc_d;
  logic [14:0] rx_crc_q, rx_crc_d;
  logic        crc_bad_q, crc_bad_d;
  logic        crc_err_q, crc_err_d;
  logic        w_crc_nxt;

  assign w_crc_nxt = w_bit ^ crc_q[14];

  // CRC-15 covers SOF through the last data bit. SOF is dominant and the
  // register starts at zero, so clearing at SOF is the same as shifting it in.
  always_comb begin
    crc_d     = crc_q;
    rx_crc_d  = rx_crc_q;
    crc_bad_d = crc_bad_q;
    crc_err_d = 1'b0;
    if (w_consume && !w_stuff_err) begin
      case (state_q)
        S_IDLE: begin
          if (!w_bit) begin
            crc_d     = 15'd0;
            rx_crc_d  = 15'd0;
            crc_bad_d = 1'b0;
          end
        end
        S_ID, S_CTRL, S_DLC, S_DATA: begin
          crc_d = {crc_q[13:0], 1'b0} ^ (w_crc_nxt ? 15'h4599 : 15'h0000);
        end
        S_CRC: begin
          rx_crc_d = {rx_crc_q[13:0], w_bit};
        end
        S_CRC_DEL: begin
          if (rx_crc_q != crc_q) begin
            crc_err_d = 1'b1;
            crc_bad_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      crc_q     <= 15'd0;
      rx_crc_q  <= 15'd0;
      crc_bad_q <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      rx_crc_q  <= rx_crc_d;
      crc_bad_q <= crc_bad_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign w_crc_bad       = crc_bad_q;
  assign bus.o_Crc_Error = crc_err_q;
`else
  assign w_crc_bad       = 1'b0;
  assign bus.o_Crc_Error = 1'b0;
`endif

  assign bus.o_Destuff_En  = destuff_q;
  assign bus.o_Id          = id_q;
  assign bus.o_Rtr         = rtr_q;
  assign bus.o_Dlc         = dlc_q;
  assign bus.o_Data        = data_q;
  assign bus.o_Frame_Valid = frame_valid_q;
  assign bus.o_Form_Error  = form_err_q;
  assign bus.o_Stuff_Error = stuff_err_q;
  assign bus.o_Busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_can_rx_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_can_rx_frame_ctrl                                         |
// | Description : Self-checking bench for can_rx_frame_ctrl. Builds frames,    |
// |               inserts stuff bits, queues the expected outcome of each      |
// |               frame and compares it when the controller pulses.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_can_rx_frame_ctrl;

  localparam int TB_MAX_BYTES = 8;
  localparam logic [3:0] K_FV = 4'b1000;
  localparam logic [3:0] K_FE = 4'b0100;
  localparam logic [3:0] K_SE = 4'b0010;
  localparam logic [3:0] K_CE = 4'b0001;

  typedef struct {
    logic [3:0]  kind;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  int   opt_crc_flip;
  int   opt_tail_dom;
  int   opt_serr_at;
  int   opt_extra_ign_at;
  int   opt_abort_at;
  logic opt_ack_val;

  can_rx_frame_ctrl_if #(.MAX_BYTES(TB_MAX_BYTES)) bus_if ();

  can_rx_frame_ctrl #(.EOF_BITS(7), .MAX_BYTES(TB_MAX_BYTES)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  logic [3:0] mon_pv;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_pv = {bus_if.o_Frame_Valid, bus_if.o_Form_Error, bus_if.o_Stuff_Error, bus_if.o_Crc_Error};
      if (mon_pv != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'(mon_pv), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", 64'(mon_pv), 64'(mon_e.kind));
          if (mon_e.kind == K_FV) begin
            check("id", 64'(bus_if.o_Id), 64'(mon_e.id));
            check("rtr", 64'(bus_if.o_Rtr), 64'(mon_e.rtr));
            check("dlc", 64'(bus_if.o_Dlc), 64'(mon_e.dlc));
            check("data", bus_if.o_Data, mon_e.data);
          end
          if (bus_if.o_Stuff_Error) check("destuff_at_serr", 64'(bus_if.o_Destuff_En), 64'd0);
        end
      end
    end
  end

  task automatic clear_opts();
    opt_crc_flip     = -1;
    opt_tail_dom     = -1;
    opt_serr_at      = -1;
    opt_extra_ign_at = -1;
    opt_abort_at     = -1;
    opt_ack_val      = 1'b0;
  endtask

  // One sample strobe; the idle cycle carries junk that must be ignored.
  task automatic drive_bit(input logic b, input logic ign, input logic serr);
    @(posedge clk); #1;
    bus_if.i_Sample        = 1'b1;
    bus_if.i_Rx_Bit        = b;
    bus_if.i_Ignora_Bit    = ign;
    bus_if.i_Eror_Stuffing = serr;
    @(posedge clk); #1;
    bus_if.i_Sample        = 1'b0;
    bus_if.i_Rx_Bit        = ~b;
    bus_if.i_Ignora_Bit    = 1'b1;
    bus_if.i_Eror_Stuffing = 1'b1;
  endtask

  task automatic send_recessive(input int n);
    for (int k = 0; k < n; k++) drive_bit(1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [10:0] id, input logic rtr, input logic ide,
                            input logic [3:0] dlc, input logic [63:0] data, input logic [3:0] kind);
    logic bits[$];
    logic [14:0] crc;
    logic nxt;
    int nb;
    logic [63:0] ones;
    exp_t e;
    logic rv;
    int rl;
    logic [9:0] tail;
    logic b;
    int last;
    bits.push_back(1'b0);
    for (int i = 10; i >= 0; i--) bits.push_back(id[i]);
    bits.push_back(rtr);
    bits.push_back(ide);
    bits.push_back(1'b0);
    for (int i = 3; i >= 0; i--) bits.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 64 : 8 * int'(dlc));
    for (int i = 0; i < nb; i++) bits.push_back(data[63-i]);
    crc = 15'd0;
    foreach (bits[i]) begin
      nxt = bits[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nxt) crc = crc ^ 15'h4599;
    end
    if (opt_crc_flip >= 0) crc = crc ^ (15'd1 << opt_crc_flip);
    for (int i = 14; i >= 0; i--) bits.push_back(crc[i]);
    if (kind != 4'b0000) begin
      ones   = '1;
      e.kind = kind;
      e.id   = id;
      e.rtr  = rtr;
      e.dlc  = dlc;
      e.data = data & ~(ones >> nb);
      exp_q.push_back(e);
    end
    last = bits.size() - 1;
    rv = 1'b1;
    rl = 0;
    for (int i = 0; i <= last; i++) begin
      if (i == opt_abort_at) return;
      if (i == opt_extra_ign_at) drive_bit(~bits[i], 1'b1, 1'b0);
      if (i == opt_serr_at) begin
        drive_bit(bits[i], 1'b0, 1'b1);
        check("destuff_after_serr", 64'(bus_if.o_Destuff_En), 64'd0);
        return;
      end
      drive_bit(bits[i], 1'b0, 1'b0);
      if (i == 0) begin
        check("destuff_sof", 64'(bus_if.o_Destuff_En), 64'd1);
        check("busy_sof", 64'(bus_if.o_Busy), 64'd1);
      end
      if (bits[i] == rv) rl++;
      else begin
        rv = bits[i];
        rl = 1;
      end
      if (rl == 5 && i < last) begin
        drive_bit(~rv, 1'b1, 1'b0);
        rv = ~rv;
        rl = 1;
      end
    end
    check("destuff_crc_end", 64'(bus_if.o_Destuff_En), 64'd0);
    tail = {1'b1, opt_ack_val, 1'b1, 7'h7F};
    for (int k = 0; k < 10; k++) begin
      b = tail[9-k];
      if (k == opt_tail_dom) b = 1'b0;
      drive_bit(b, 1'b0, 1'b0);
      if (k == opt_tail_dom) return;
    end
    if (kind == K_FV) check("fv_after_eof", 64'(bus_if.o_Frame_Valid), 64'd1);
    check("busy_after_eof", 64'(bus_if.o_Busy), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_opts();
    bus_if.i_Sample        = 1'b0;
    bus_if.i_Rx_Bit        = 1'b1;
    bus_if.i_Ignora_Bit    = 1'b0;
    bus_if.i_Eror_Stuffing = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus_if.o_Busy), 64'd0);
    check("rst_destuff", 64'(bus_if.o_Destuff_En), 64'd0);
    check("rst_id", 64'(bus_if.o_Id), 64'd0);
    check("rst_data", bus_if.o_Data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reference frame, then the same frame with a bogus ignored 6th ID bit.
    send_frame(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, K_FV);
    send_recessive(3);
    check("hold_id", 64'(bus_if.o_Id), 64'h123);
    check("hold_data", bus_if.o_Data, 64'hA55A_0000_0000_0000);
    opt_extra_ign_at = 6;
    send_frame(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, K_FV);
    clear_opts();

    // DLC above MAX_BYTES, then a short frame whose tail bytes must read 0.
    send_frame(11'h6B1, 1'b0, 1'b0, 4'd15, 64'hFFFF_0000_F0F0_1234, K_FV);
    send_frame(11'h000, 1'b0, 1'b0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, K_FV);
    opt_ack_val = 1'b1;
    send_frame(11'h7FF, 1'b1, 1'b0, 4'd3, 64'hDEAD_BEEF_0000_0000, K_FV);
    clear_opts();
    send_frame(11'h2AA, 1'b0, 1'b0, 4'd0, 64'd0, K_FV);

    // Stuff error in DATA, dominant restarts the idle count, then recovery.
    opt_serr_at = 19 + 5;
    send_frame(11'h0F0, 1'b0, 1'b0, 4'd4, 64'h1234_5678_0000_0000, K_SE);
    clear_opts();
    send_recessive(3);
    drive_bit(1'b0, 1'b0, 1'b0);
    send_recessive(6);
    check("serr_wait_busy", 64'(bus_if.o_Busy), 64'd1);
    send_recessive(1);
    check("serr_wait_done", 64'(bus_if.o_Busy), 64'd0);
    send_frame(11'h321, 1'b0, 1'b0, 4'd1, 64'h7E00_0000_0000_0000, K_FV);

    // Dominant at the 4th EOF bit.
    opt_tail_dom = 6;
    send_frame(11'h456, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, K_FE);
    clear_opts();
    check("eof_err_busy", 64'(bus_if.o_Busy), 64'd1);
    send_recessive(6);
    check("eof_wait_busy", 64'(bus_if.o_Busy), 64'd1);
    send_recessive(1);
    check("eof_wait_done", 64'(bus_if.o_Busy), 64'd0);

    // Dominant CRC delimiter and ACK delimiter.
    opt_tail_dom = 0;
    send_frame(11'h111, 1'b0, 1'b0, 4'd1, 64'h8100_0000_0000_0000, K_FE);
    clear_opts();
    send_recessive(7);
    check("crcdel_wait_done", 64'(bus_if.o_Busy), 64'd0);
    opt_tail_dom = 2;
    send_frame(11'h222, 1'b0, 1'b0, 4'd1, 64'h1800_0000_0000_0000, K_FE);
    clear_opts();
    send_recessive(7);
    check("ackdel_wait_done", 64'(bus_if.o_Busy), 64'd0);

    // Extended-format frame is a form error at IDE.
    opt_abort_at = 14;
    send_frame(11'h333, 1'b0, 1'b1, 4'd1, 64'd0, K_FE);
    clear_opts();
    check("ide_destuff", 64'(bus_if.o_Destuff_En), 64'd0);
    send_recessive(7);
    check("ide_wait_done", 64'(bus_if.o_Busy), 64'd0);

`ifdef CAN_RX_CRC_CHECK_EN
    opt_crc_flip = 4;
    send_frame(11'h4C3, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, K_CE);
    clear_opts();
`endif

    // Asynchronous reset in the middle of DATA.
    opt_abort_at = 29;
    send_frame(11'h5A5, 1'b0, 1'b0, 4'd4, 64'hCAFE_F00D_0000_0000, 4'b0000);
    clear_opts();
    check("id_before_rst", 64'(bus_if.o_Id), 64'h5A5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus_if.o_Busy), 64'd0);
    check("arst_destuff", 64'(bus_if.o_Destuff_En), 64'd0);
    check("arst_id", 64'(bus_if.o_Id), 64'd0);
    check("arst_dlc", 64'(bus_if.o_Dlc), 64'd0);
    check("arst_data", bus_if.o_Data, 64'd0);
    check("arst_pulses", 64'({bus_if.o_Frame_Valid, bus_if.o_Form_Error,
                              bus_if.o_Stuff_Error, bus_if.o_Crc_Error, bus_if.o_Rtr}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, K_FV);

    repeat (5) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/can_rx_frame_ctrl.md
CAN_RX_FRAME_CTRL -- requirements
Module: can_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter EOF_BITS, default 7: recessive bits expected in EOF, and recessive bits needed to leave WAIT_IDLE.
REQ-002 SHALL have parameter MAX_BYTES, default 8: maximum captured data bytes; the DLC is clamped to this value.
REQ-003 i_Clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 i_Rst_n  in  1  asynchronous active-low reset.
REQ-005 i_Sample  in  1  one-cycle bit sample strobe; every other input except reset is ignored when it is 0.
REQ-006 i_Rx_Bit  in  1  sampled bus bit; 0 = dominant.
REQ-007 i_Ignora_Bit  in  1  destuffer flag: the current sampled bit is a stuff bit; valid with i_Sample.
REQ-008 i_Eror_Stuffing  in  1  destuffer flag: 6th equal bit detected; valid with i_Sample.
REQ-009 o_Destuff_En  out  1  high while in the stuffed region (SOF through last CRC bit).
REQ-010 o_Id  out  11  captured identifier, MSB first on the bus.
REQ-011 o_Rtr  out  1  captured RTR bit.
REQ-012 o_Dlc  out  4  captured DLC, unclamped.
REQ-013 o_Data  out  8*MAX_BYTES  data bytes; byte 0 in the MS byte, filled MSB first.
REQ-014 o_Frame_Valid  out  1  one-cycle pulse on the i_Clk after the sample of the last EOF bit.
REQ-015 o_Form_Error  out  1  one-cycle pulse on a fixed-form violation.
REQ-016 o_Stuff_Error  out  1  one-cycle pulse on a stuff error inside the stuffed region.
REQ-017 o_Crc_Error  out  1  one-cycle pulse on a CRC mismatch.
REQ-018 o_Busy  out  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, ID, CTRL, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, WAIT_IDLE. CTRL consumes RTR, IDE and r0.
REQ-020 One bit counter, 7 bits wide. It clears on every state entry and increments once per consumed bit.
REQ-021 A bit is consumed only when i_Sample=1 and (i_Ignora_Bit=0 or o_Destuff_En=0).
- Stuff bits are discarded.
- The state and counter do not advance on a stuff bit.
REQ-022 IDLE: a dominant bit -> ID. This bit is the SOF. o_Destuff_En goes high on the same edge.
REQ-023 ID: shift 11 bits into o_Id, then -> CTRL.
REQ-024 CTRL: 3 bits (RTR, IDE, r0).
- IDE=1 -> o_Form_Error, then -> WAIT_IDLE.
- Otherwise -> DLC.
REQ-025 DLC: 4 bits.
- Data length = min(DLC, MAX_BYTES), or 0 if RTR=1.
- Length 0 -> CRC; otherwise -> DATA.
REQ-026 DATA: shift 8*length bits, then -> CRC. Bytes beyond the length keep their reset value 0; they are cleared at SOF.
REQ-027 CRC: 15 bits, then -> CRC_DEL. o_Destuff_En drops on the edge that consumes the 15th CRC bit.
REQ-028 Fixed-form fields. Dominant in CRC_DEL, ACK_DEL or EOF -> o_Form_Error, then -> WAIT_IDLE.
- CRC_DEL: 1 recessive bit.
- ACK: 1 bit, any value.
- ACK_DEL: 1 recessive bit.
- EOF: EOF_BITS recessive bits.
REQ-029 After the last EOF bit -> IDLE with an o_Frame_Valid pulse, unless o_Crc_Error fired for this frame.
REQ-030 i_Eror_Stuffing=1 with i_Sample and o_Destuff_En=1 -> o_Stuff_Error, o_Destuff_En low, then -> WAIT_IDLE. This takes priority over every other transition.
- i_Eror_Stuffing is ignored outside the stuffed region.
REQ-031 WAIT_IDLE: count consecutive recessive bits; any dominant bit restarts the count. EOF_BITS recessive bits -> IDLE.
REQ-032 o_Id, o_Rtr, o_Dlc and o_Data hold their values from o_Frame_Valid until the next SOF.

Reset
REQ-033 Asserting i_Rst_n low at any time, including mid-frame, SHALL immediately put the block in IDLE.
- Counters cleared, CRC register cleared.
- All outputs 0 and all capture registers 0.
REQ-034 No pulse output SHALL fire on the first i_Clk after reset release.

Configuration
REQ-035 With CAN_RX_CRC_CHECK_EN defined, the block SHALL check the CRC:
- Run CRC-15 (polynomial 0x4599, init 0) over the destuffed bits from SOF through the end of DATA.
- Compare it with the received CRC at the CRC_DEL sample; a mismatch -> o_Crc_Error.
- Reception continues to EOF, but o_Frame_Valid is suppressed.
REQ-036 Without CAN_RX_CRC_CHECK_EN, no CRC logic SHALL exist and o_Crc_Error SHALL be tied to 0.

Verification
REQ-037 Frame ID=0x123, RTR=0, DLC=2, data 0xA55A, correct CRC, stuffing applied, clean EOF -> o_Frame_Valid, o_Id=0x123, o_Dlc=2, o_Data MS 16 bits 0xA55A, rest 0.
REQ-038 i_Ignora_Bit=1 on the 6th ID bit -> that bit is not shifted and the final o_Id is unchanged versus the unstuffed reference.
REQ-039 i_Eror_Stuffing=1 during DATA -> o_Stuff_Error pulse, o_Destuff_En 0 on the same edge; no o_Frame_Valid until 7 recessive bits and a new frame.
REQ-040 DLC=15 with MAX_BYTES=8 -> 64 data bits consumed, o_Dlc=15, o_Frame_Valid asserted.
REQ-041 Dominant bit at the 4th EOF position -> o_Form_Error, WAIT_IDLE, then IDLE after 7 recessive bits.
REQ-042 With CAN_RX_CRC_CHECK_EN, one CRC bit flipped -> o_Crc_Error pulse, no o_Frame_Valid. i_Rst_n low mid-DATA -> all outputs 0 immediately.
